spi_host_master: RTL and testbench



---
 rtl/spi_host_master.sv | 164 ++++++++++++++++
 tb/tb_spi_host_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// SPI mode-0 host master: serialises {cmd, addr, wdata} or {cmd, addr}, dummy periods and
// read data for one 32-bit word per command, then pulses a one-cycle response.
module spi_host_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_valid_o,
  output logic        rsp_write_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        cs_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StShift, StDummy, StRdata, StHold, StGap
  } state_e;

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [6:0] BitsWr   = 7'd71;
  localparam logic [6:0] BitsRd   = 7'(71 + DUMMY_CYCLES);
  localparam logic [6:0] DummyTop = 7'(32 + DUMMY_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        phase_q, phase_d;    // 1 = sclk high phase
  logic [6:0]  bit_q, bit_d;        // bit periods left, counts down from N-1
  logic [71:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        write_q, write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rdata_q, rdata_d;
  logic [6:0]  bit_nxt;
  logic        div_done;

  assign div_done = (div_q == 8'd0);
  assign bit_nxt  = bit_q - 7'd1;

  // Next-state logic: half-period timing, bit sequencing and shift registers.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    write_d     = write_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StSetup;
          div_d   = DivLast;
          phase_d = 1'b0;
          write_d = cmd_write_i;
          // Read frames carry zeros after the address so mosi stays low.
          tx_d    = {3'b000, cmd_write_i, cmd_be_i, cmd_addr_i,
                     (cmd_write_i ? cmd_wdata_i : 32'h0)};
          bit_d   = cmd_write_i ? BitsWr : BitsRd;
          rx_d    = 32'h0;
        end
      end
      StSetup: begin
        if (div_done) begin
          state_d = StShift;
          phase_d = 1'b1;
          div_d   = DivLast;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StShift, StDummy, StRdata: begin
        if (!div_done) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DivLast;
          if (phase_q) begin
            // Last cycle of the high phase: sample miso, advance mosi with the fall.
            if (state_q == StRdata) rx_d = {rx_q[30:0], miso_i};
            tx_d    = {tx_q[70:0], 1'b0};
            phase_d = 1'b0;
            // The low phase of the final bit is spent in HOLD.
            if (bit_q == 7'd0) state_d = StHold;
          end else begin
            phase_d = 1'b1;
            bit_d   = bit_nxt;
            if (!write_q && (bit_nxt < 7'd32))         state_d = StRdata;
            else if (!write_q && (bit_nxt < DummyTop)) state_d = StDummy;
            else                                       state_d = StShift;
          end
        end
      end
      StHold: begin
        if (div_done) begin
          state_d     = StGap;
          div_d       = DivLast;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          if (!write_q) rdata_d = rx_q;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StGap: begin
        if (div_done) state_d = StIdle;
        else          div_d   = div_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      div_q       <= 8'd0;
      phase_q     <= 1'b0;
      bit_q       <= 7'd0;
      tx_q        <= 72'h0;
      rx_q        <= 32'h0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs decode from registered state so reset forces them immediately.
  always_comb begin
    cmd_ready_o = (state_q == StIdle) && !rst_i;
    busy_o      = (state_q != StIdle);
    cs_o        = !(state_q inside {StSetup, StShift, StDummy, StRdata, StHold});
    sclk_o      = phase_q && (state_q inside {StShift, StDummy, StRdata});
    mosi_o      = tx_q[71] && (state_q inside {StSetup, StShift});
    rsp_valid_o = rsp_valid_q;
    rsp_write_o = rsp_write_q;
    rsp_rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Scoreboard bench: two instances (CLK_DIV=4/DUMMY=8 and CLK_DIV=2/DUMMY=0) with an SPI slave model.
module tb_spi_host_master;

  typedef struct {
    int          inst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] sword;
    logic [31:0] rdata;
    int          t;
    logic [7:0]  cmd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic [3:0]  cmd_be    [2];
  logic        rsp_valid [2];
  logic        rsp_write [2];
  logic [31:0] rsp_rdata [2];
  logic        busy      [2];
  logic        sclk      [2];
  logic        cs        [2];
  logic        mosi      [2];
  logic        miso      [2];

  int          cdiv [2] = '{4, 2};
  int          dum  [2] = '{8, 0};
  logic [31:0] sword [2];
  logic [95:0] cap [2];
  int          rises [2];
  int          acc_cyc [2];
  int          cslow [2];
  int          gap_left [2];
  int          last_rsp_cyc [2];
  logic        cs_prev [2];
  logic        sclk_prev [2];

  int   cyc = 0;
  int   rsp_cnt = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  vec_t vecs [7];
  vec_t sb [$];

  spi_host_master #(.CLK_DIV(4), .DUMMY_CYCLES(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_write_i(cmd_write[0]),
    .cmd_addr_i(cmd_addr[0]), .cmd_wdata_i(cmd_wdata[0]), .cmd_be_i(cmd_be[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_write_o(rsp_write[0]), .rsp_rdata_o(rsp_rdata[0]),
    .busy_o(busy[0]), .sclk_o(sclk[0]), .cs_o(cs[0]), .mosi_o(mosi[0]), .miso_i(miso[0])
  );

  spi_host_master #(.CLK_DIV(2), .DUMMY_CYCLES(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_write_i(cmd_write[1]),
    .cmd_addr_i(cmd_addr[1]), .cmd_wdata_i(cmd_wdata[1]), .cmd_be_i(cmd_be[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_write_o(rsp_write[1]), .rsp_rdata_o(rsp_rdata[1]),
    .busy_o(busy[1]), .sclk_o(sclk[1]), .cs_o(cs[1]), .mosi_o(mosi[1]), .miso_i(miso[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input int k);
    vec_t        e;
    int          n;
    logic [95:0] hdr;
    logic [95:0] dm;
    rsp_cnt++;
    last_rsp_cyc[k] = cyc;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_rsp: got response on instance %0d, expected none", k);
    end else begin
      e = sb.pop_front();
      chk("rsp_inst", 96'(k), 96'(e.inst));
      chk("rsp_write", 96'(rsp_write[k]), 96'(e.wr));
      chk("rsp_rdata", 96'(rsp_rdata[k]), 96'(e.rdata));
      chk("rsp_cycle", 96'(cyc - acc_cyc[k]), 96'(e.t));
      chk("cs_low_cycles", 96'(cslow[k]), 96'(e.t - 1));
      chk("rsp_cs_high", 96'(cs[k]), 96'd1);
      n = e.wr ? 72 : 72 + dum[k];
      chk("sclk_periods", 96'(rises[k]), 96'(n));
      hdr = cap[k] >> (n - 40);
      chk("frame_hdr", 96'(hdr[39:0]), 96'({e.cmd, e.addr}));
      if (e.wr) begin
        chk("frame_wdata", 96'(cap[k][31:0]), 96'(e.wdata));
      end else if (dum[k] > 0) begin
        dm = (cap[k] >> 32) & ((96'd1 << dum[k]) - 96'd1);
        chk("dummy_mosi", dm, 96'd0);
      end
      gap_left[k] = cdiv[k] - 1;
    end
  endtask

  // Monitor and slave model, sampled on the falling clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cs_prev[k]   = 1'b1;
        sclk_prev[k] = 1'b0;
        gap_left[k]  = 0;
        miso[k]      = 1'b0;
      end else begin
        int idx;
        if (cmd_valid[k] && cmd_ready[k]) begin
          acc_cyc[k] = cyc;
          cslow[k]   = 0;
        end
        if (!cs[k]) cslow[k]++;
        if (!cs[k] && cs_prev[k]) begin
          cap[k]   = '0;
          rises[k] = 0;
        end
        if (sclk[k] && !sclk_prev[k]) begin
          cap[k] = {cap[k][94:0], mosi[k]};
          rises[k]++;
          if (rises[k] == 1) chk("first_rise", 96'(cyc - acc_cyc[k]), 96'(1 + cdiv[k]));
        end
        idx = rises[k] - 41 - dum[k];
        miso[k] = (sclk[k] && idx >= 0 && idx < 32) ? sword[k][31 - idx] : 1'b0;
        if (gap_left[k] > 0) begin
          chk("gap_cs_high", 96'(cs[k]), 96'd1);
          gap_left[k]--;
        end
        if (rsp_valid[k]) check_rsp(k);
        cs_prev[k]   = cs[k];
        sclk_prev[k] = sclk[k];
      end
    end
  end

  task automatic issue(input int i, input bit keep, input bit track);
    int k;
    bit got;
    @(posedge clk);
    #1;
    k = vecs[i].inst;
    cmd_write[k] = vecs[i].wr;
    cmd_addr[k]  = vecs[i].addr;
    cmd_wdata[k] = vecs[i].wdata;
    cmd_be[k]    = vecs[i].be;
    cmd_valid[k] = 1'b1;
    if (!vecs[i].wr) sword[k] = vecs[i].sword;
    if (track) sb.push_back(vecs[i]);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready[k]) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: vector %0d not accepted within 3000 cycles", i);
    end
    last_acc = cyc;
    if (!keep) begin
      // Scramble the inputs after accept; the frame must not notice.
      @(posedge clk);
      #1;
      cmd_valid[k] = 1'b0;
      cmd_write[k] = ~cmd_write[k];
      cmd_addr[k]  = ~cmd_addr[k];
      cmd_wdata[k] = ~cmd_wdata[k];
      cmd_be[k]    = ~cmd_be[k];
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy[0] && !busy[1]) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: %0d responses still outstanding", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt0;
    int  first_rsp;
    bit  hi;
    //          inst wr  addr          wdata         be    slave word    rdata after   T    cmd
    vecs[0] = '{0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,        32'h0,        581, 8'h1F};
    vecs[1] = '{0, 1'b0, 32'h8000_0004, 32'h5555_5555, 4'hF, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 645, 8'h0F};
    vecs[2] = '{0, 1'b1, 32'h0000_0020, 32'h0000_00FF, 4'h3, 32'h0,        32'hA5A5_0F0F, 581, 8'h13};
    vecs[3] = '{0, 1'b0, 32'h0000_0024, 32'h0,         4'hC, 32'h1234_5678, 32'h1234_5678, 645, 8'h0C};
    vecs[4] = '{0, 1'b1, 32'h0000_0028, 32'hCAFE_F00D, 4'hF, 32'h0,        32'h1234_5678, 581, 8'h1F};
    // 1 + 2 + 2*2*72
    vecs[5] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'h1, 32'h0000_0001, 32'h0000_0001, 291, 8'h01};
    vecs[6] = '{0, 1'b0, 32'h0000_0050, 32'h0,         4'hF, 32'hFFFF_FFFF, 32'h0,        645, 8'h0F};
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_write[k] = 1'b0;
      cmd_addr[k]  = 32'h0;
      cmd_wdata[k] = 32'h0;
      cmd_be[k]    = 4'h0;
      sword[k]     = 32'h0;
      last_rsp_cyc[k] = 0;
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd_ready", 96'(cmd_ready[k]), 96'd0);
      chk("rst_rsp_valid", 96'(rsp_valid[k]), 96'd0);
      chk("rst_rsp_write", 96'(rsp_write[k]), 96'd0);
      chk("rst_rsp_rdata", 96'(rsp_rdata[k]), 96'd0);
      chk("rst_busy", 96'(busy[k]), 96'd0);
      chk("rst_sclk", 96'(sclk[k]), 96'd0);
      chk("rst_cs", 96'(cs[k]), 96'd1);
      chk("rst_mosi", 96'(mosi[k]), 96'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst0", 96'(cmd_ready[0]), 96'd1);
    chk("ready_after_rst1", 96'(cmd_ready[1]), 96'd1);

    issue(0, 1'b0, 1'b1);
    wait_idle();
    issue(1, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back: valid stays high across the write and the following read.
    issue(2, 1'b1, 1'b1);
    issue(3, 1'b0, 1'b1);
    first_rsp = last_rsp_cyc[0];
    chk("b2b_accept_spacing", 96'(last_acc - first_rsp), 96'd4);
    issue(4, 1'b0, 1'b1);
    wait_idle();

    issue(5, 1'b0, 1'b1);
    wait_idle();

    // Abandon a read mid-frame with an asynchronous reset while sclk is high.
    issue(6, 1'b0, 1'b0);
    hi = 1'b0;
    for (int n = 0; n < 200 && !hi; n++) begin
      @(negedge clk);
      if (sclk[0]) hi = 1'b1;
    end
    chk("abort_saw_sclk_high", 96'(hi), 96'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", 96'(cs[0]), 96'd1);
    chk("abort_sclk", 96'(sclk[0]), 96'd0);
    chk("abort_busy", 96'(busy[0]), 96'd0);
    chk("abort_mosi", 96'(mosi[0]), 96'd0);
    chk("abort_ready", 96'(cmd_ready[0]), 96'd0);
    cnt0 = rsp_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 96'(cmd_ready[0]), 96'd1);
    repeat (800) @(negedge clk);
    chk("abort_no_rsp", 96'(rsp_cnt), 96'(cnt0));
    chk("abort_cs_idle", 96'(cs[0]), 96'd1);
    chk("sb_drained", 96'(sb.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
